instr_mem_loader: RTL
=====================

// Module: instr_mem_loader
// PURPOSE
//   Hardware program loader for the MIPS core; fills instruction memory from a byte stream at run time.
//   It holds the CPU while it receives a length header and the machine-code words, then writes each word into IM.
//   When loading completes it clears the PC and releases the CPU.
//   Sits between a host byte source (UART/JTAG bridge) and the IM write port / PC clear of MIPS.
// PARAMETERS
//   ADDR_WIDTH  10  IM byte-address width; MAX_WORDS = 2**(ADDR_WIDTH-2) (default 256 words)
// PORTS
//   clk         in   1           single clock, rising edge
//   reset       in   1           synchronous, active-high
//   in_valid    in   1           host byte valid
//   in_data     in   8           host byte
//   in_ready    out  1           loader can accept byte this cycle
//   im_we       out  1           IM word write strobe
//   im_addr     out  ADDR_WIDTH  IM byte address of word written (always multiple of 4)
//   im_wdata    out  32          IM write data
//   cpu_hold    out  1           1 = CPU stalled (PC/RF/DM writes inhibited)
//   pc_clear    out  1           one-cycle pulse: PC <= 0
//   done        out  1           sticky: last load completed OK
//   error       out  1           sticky: length header exceeded MAX_WORDS
// BEHAVIOUR
//   Handshake: byte consumed on a rising edge where in_valid && in_ready. in_data is ignored otherwise.
//   Frame: LEN_HI, LEN_LO (N, 16-bit, big-endian), then N*4 data bytes; word = {b0,b1,b2,b3}, b0 = MSB.
//   FSM states and in_ready:
//     IDLE    in_ready=1; byte accepted -> LEN_HI := byte, done:=0, cpu_hold:=1, -> LEN
//     LEN     in_ready=1; byte accepted -> N := {LEN_HI,byte}, word_idx:=0, byte_cnt:=0;
//             N==0 -> FINISH; N>MAX_WORDS -> ERROR; else -> DATA
//     DATA    in_ready=1; shift byte into assembly reg, byte_cnt++; 4th byte -> WRITE
//     WRITE   in_ready=0; im_we=1, im_addr=word_idx<<2, im_wdata=assembled word;
//             word_idx==N-1 -> FINISH, else word_idx++, byte_cnt:=0, -> DATA
//     FINISH  in_ready=0; pc_clear=1 for this cycle only; -> IDLE with done:=1, cpu_hold:=0
//     ERROR   in_ready=0, error=1, cpu_hold=1; exited only by reset
//   Latency: 4th byte of a word accepted at edge t -> im_we high in cycle t+1.
//     Final word: pc_clear high in cycle t+2; cpu_hold=0 and done=1 from cycle t+3.
//   im_we, pc_clear and in_ready are decoded from state; cpu_hold, done and error are registers.
//   im_addr/im_wdata hold their last value when im_we=0 (don't-care to IM).
//   word_idx is ADDR_WIDTH-2 bits wide; N<=MAX_WORDS, so it never wraps. N==MAX_WORDS fills IM exactly.
//   in_valid high during WRITE/FINISH/ERROR: byte is not consumed; host must hold it.
//   Reload: a byte accepted in IDLE after done starts a new frame. It re-asserts cpu_hold and clears done.
//     Words not rewritten keep their old IM contents.
//   Reset values: state=IDLE, in_ready=1, im_we=0, im_addr=0, im_wdata=0, cpu_hold=1, pc_clear=0,
//     done=0, error=0, all counters 0. The CPU stays held from reset until the first successful load.
//   Reset mid-frame: abandon frame; IM words already written stay; next frame restarts at address 0.
// TESTING
//   T1 reset 2 cycles -> in_ready=1, cpu_hold=1, im_we=0, pc_clear=0, done=0, error=0.
//   T2 stream 00 02 20 08 00 05 AC 08 00 00, in_valid continuous
//      -> im_we @addr 0 data 20080005, then @addr 4 data AC080000.
//      -> then one pc_clear pulse; then done=1, cpu_hold=0.
//   T3 same frame with in_valid toggling 1/0 and held high across WRITE cycles
//      -> identical IM writes; no byte lost or duplicated.
//   T4 stream 00 00 -> no im_we; pc_clear pulse 1 cycle after LEN_LO accept; done=1, cpu_hold=0.
//   T5 stream 01 01 (N=257 > 256) -> error=1, in_ready=0, cpu_hold=1 held 20 cycles, no im_we.
//      -> reset clears error.
//   T6 frame N=3, reset after 2nd im_we, then frame N=1 word 12345678
//      -> write @addr 0 data 12345678, done=1.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Program loader: receives a length-prefixed byte stream, writes the words into instruction
// memory while holding the CPU, then clears the PC and releases the CPU.
module instr_mem_loader #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [31:0]           im_wdata,
    output logic                  cpu_hold,
    output logic                  pc_clear,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned IdxW     = ADDR_WIDTH - 2;
    localparam logic [16:0] MaxWords = 17'(1 << IdxW);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StWrite,
        StFinish,
        StError
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [15:0]           n_q, n_d;
    logic [IdxW-1:0]       word_idx_q, word_idx_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           asm_q, asm_d;
    logic [ADDR_WIDTH-1:0] im_addr_q, im_addr_d;
    logic [31:0]           im_wdata_q, im_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic        accept;
    logic [15:0] len_full;

    assign accept   = in_valid && in_ready;
    assign len_full = {len_hi_q, in_data};

    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        error_d    = error_q;
        in_ready   = 1'b0;
        im_we      = 1'b0;
        pc_clear   = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (accept) begin
                    len_hi_d   = in_data;
                    done_d     = 1'b0;
                    cpu_hold_d = 1'b1;
                    state_d    = StLen;
                end
            end
            StLen: begin
                in_ready = 1'b1;
                if (accept) begin
                    n_d        = len_full;
                    word_idx_d = '0;
                    byte_cnt_d = 2'd0;
                    if (len_full == 16'd0) begin
                        state_d = StFinish;
                    end else if ({1'b0, len_full} > MaxWords) begin
                        error_d    = 1'b1;
                        cpu_hold_d = 1'b1;
                        state_d    = StError;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                in_ready = 1'b1;
                if (accept) begin
                    asm_d      = {asm_q[15:0], in_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // Latch the full word and its address so they stay stable after the write.
                    if (byte_cnt_q == 2'd3) begin
                        im_addr_d  = {word_idx_q, 2'b00};
                        im_wdata_d = {asm_q, in_data};
                        state_d    = StWrite;
                    end
                end
            end
            StWrite: begin
                im_we = 1'b1;
                if ({1'b0, n_q} == 17'(word_idx_q) + 17'd1) begin
                    state_d = StFinish;
                end else begin
                    word_idx_d = word_idx_q + 1'b1;
                    byte_cnt_d = 2'd0;
                    state_d    = StData;
                end
            end
            StFinish: begin
                pc_clear   = 1'b1;
                done_d     = 1'b1;
                cpu_hold_d = 1'b0;
                state_d    = StIdle;
            end
            StError: begin
                cpu_hold_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            len_hi_q   <= 8'd0;
            n_q        <= 16'd0;
            word_idx_q <= '0;
            byte_cnt_q <= 2'd0;
            asm_q      <= 24'd0;
            im_addr_q  <= '0;
            im_wdata_q <= 32'd0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            n_q        <= n_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule
